// File: rtl/fir_decim_out.sv
// ---------------------------------------------------------------------------
// fir_decim_out
//
// Output stage for a decimating FIR. It accumulates DECIM accepted input
// samples into one sum, scales the sum by an arithmetic right shift, reduces
// the result to 16 bits and queues it in a 4-entry FIFO for the consumer.
//
// Parameters:
//   DECIM  decimation factor (1, 2, 4, 8 or 16)
//   SHIFT  arithmetic right shift applied to each dumped sum (0..log2(DECIM))
//
// Compile-time option:
//   FIR_DECIM_SAT_EN  defined   -> out-of-range results clamp to 32767/-32768
//                     undefined -> out-of-range results wrap to their low
//                                  16 bits (two's complement)
//   ovf is set on any out-of-range result in both modes.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   x          signed 16-bit FIR output sample
//   x_valid    x is valid this cycle (no input backpressure)
//   y          signed 16-bit decimated sample at the FIFO head
//   y_valid    y holds a valid sample
//   y_ready    consumer accepts y; pop when y_valid && y_ready
//   ovf        sticky: a result exceeded the signed 16-bit range
//   drop       sticky: a result was lost because the FIFO was full
//   clr_flags  clears ovf and drop (a simultaneous new set wins)
// ---------------------------------------------------------------------------
module fir_decim_out #(
    parameter int DECIM = 4,
    parameter int SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] x,
    input  logic               x_valid,
    output logic signed [15:0] y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               ovf,
    output logic               drop,
    input  logic               clr_flags
);

    // A 1-bit phase is kept for DECIM=1 so the vector is never zero-width;
    // it simply stays at 0 because every sample is a dump.
    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);

    logic signed [19:0]  acc_q, acc_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic signed [15:0]  mem_q [4];
    logic signed [15:0]  mem_d [4];
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [2:0]          count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;

    logic signed [19:0]  sum;
    logic signed [19:0]  result;
    logic signed [15:0]  reduced;
    logic                out_of_range;
    logic                dump;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                drop_set;

    // Datapath: running sum, scaling and 16-bit reduction of the dumped value.
    always_comb begin
        sum          = acc_q + $signed({{4{x[15]}}, x});
        result       = sum >>> SHIFT;
        out_of_range = (result > 20'sd32767) || (result < -20'sd32768);
`ifdef FIR_DECIM_SAT_EN
        if (result > 20'sd32767) begin
            reduced = 16'sh7FFF;
        end else if (result < -20'sd32768) begin
            reduced = 16'sh8000;
        end else begin
            reduced = result[15:0];
        end
`else
        reduced = result[15:0];
`endif
        dump = x_valid && (phase_q == LAST_PHASE);
    end

    // Accumulator and phase only move on accepted samples.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        if (x_valid) begin
            if (dump) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // FIFO control. When full, a simultaneous pop frees the head slot, which
    // is exactly where wr_ptr points, so the new result lands behind the
    // remaining entries and order is preserved.
    always_comb begin
        pop      = (count_q != 3'd0) && y_ready;
        full     = (count_q == 3'd4);
        push_ok  = dump && (!full || pop);
        drop_set = dump && full && !pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = reduced;
        end
        wr_ptr_d = wr_ptr_q + 2'(push_ok);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q + 3'(push_ok) - 3'(pop);
    end

    // Sticky flags: a new set condition takes priority over a clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_flags) begin
            ovf_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (dump && out_of_range) begin
            ovf_d = 1'b1;
        end
        if (drop_set) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            phase_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            phase_q  <= phase_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Head entry is read straight out of the storage registers.
    assign y       = mem_q[rd_ptr_q];
    assign y_valid = (count_q != 3'd0);
    assign ovf     = ovf_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_out
//
// Self-checking bench for fir_decim_out (DECIM=4, SHIFT=1). A frame-level
// reference model (list of samples per frame, queue of pending outputs,
// sticky flag bits) is advanced once per clock alongside the DUT.
// ---------------------------------------------------------------------------
module tb_fir_decim_out;

    localparam int DECIM = 4;
    localparam int SHIFT = 1;

    logic               clk;
    logic               rst;
    logic signed [15:0] x;
    logic               x_valid;
    logic signed [15:0] y;
    logic               y_valid;
    logic               y_ready;
    logic               ovf;
    logic               drop;
    logic               clr_flags;

    int n_compared;
    int n_mismatched;

    // Reference model state
    int frame[$];
    int m_fifo[$];
    bit m_ovf;
    bit m_drop;

    fir_decim_out #(.DECIM(DECIM), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .ovf       (ovf),
        .drop      (drop),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reduce a scaled frame sum to the 16-bit value the consumer should see.
    function automatic int reduce16(input int r);
        int v;
`ifdef FIR_DECIM_SAT_EN
        if (r > 32767) v = 32767;
        else if (r < -32768) v = -32768;
        else v = r;
`else
        v = r & 16'hFFFF;
        if (v >= 32768) v = v - 65536;
`endif
        return v;
    endfunction

    // Drive one clock worth of inputs and advance the reference model with
    // the behaviour that edge should produce; returns #1 after the edge.
    task automatic drive_cycle(input bit xv, input int xs, input bit rdy,
                               input bit clr, input bit rs);
        bit pop;
        bit have;
        bit ovf_set;
        bit drop_set;
        int total;
        int r;
        int val;
        x         = 16'(xs);
        x_valid   = xv;
        y_ready   = rdy;
        clr_flags = clr;
        rst       = rs;
        if (rs) begin
            frame.delete();
            m_fifo.delete();
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end else begin
            pop      = (m_fifo.size() != 0) && rdy;
            have     = 1'b0;
            ovf_set  = 1'b0;
            drop_set = 1'b0;
            val      = 0;
            if (xv) begin
                frame.push_back(xs);
                if (frame.size() == DECIM) begin
                    total = 0;
                    foreach (frame[i]) total += frame[i];
                    r       = total >>> SHIFT;
                    ovf_set = (r > 32767) || (r < -32768);
                    val     = reduce16(r);
                    have    = 1'b1;
                    frame.delete();
                end
            end
            if (have && m_fifo.size() == 4 && !pop) drop_set = 1'b1;
            if (pop) void'(m_fifo.pop_front());
            if (have && !drop_set) m_fifo.push_back(val);
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 1'b0;
            end
            if (ovf_set)  m_ovf  = 1'b1;
            if (drop_set) m_drop = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1234, 1'b1, 1'b1, 1'b1);
        n_compared++;
        if (y_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_y_valid: got %0b want 0", y_valid);
        end
        n_compared++;
        if (y !== 16'sd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_y: got %0d want 0", y);
        end
        n_compared++;
        if (ovf !== 1'b0 || drop !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got ovf=%0b drop=%0b want 0/0", ovf, drop);
        end
    endtask

    task automatic test_basic();
        int samples[4] = '{100, 200, 300, 400};
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, samples[i], 1'b1, 1'b0, 1'b0);
            if (i < 3) begin
                n_compared++;
                if (y_valid !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL basic_early_valid: sample %0d got %0b want 0", i, y_valid);
                end
            end
        end
        n_compared++;
        if (y_valid !== 1'b1 || y !== 16'sd500) begin
            n_mismatched++;
            $display("[TB] FAIL basic_out: got valid=%0b y=%0d want 1/500", y_valid, y);
        end
        n_compared++;
        if (ovf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_ovf: got %0b want 0", ovf);
        end
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_compared++;
        if (y_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_one_cycle: got valid=%0b want 0", y_valid);
        end
    endtask

    task automatic test_overflow_pos();
        logic signed [15:0] exp_y;
`ifdef FIR_DECIM_SAT_EN
        exp_y = 16'sd32767;
`else
        exp_y = -16'sd2;
`endif
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32767, 1'b0, 1'b0, 1'b0);
        n_compared++;
        if (y_valid !== 1'b1 || y !== exp_y) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_pos_y: got valid=%0b y=%0d want 1/%0d", y_valid, y, exp_y);
        end
        n_compared++;
        if (ovf !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_pos_flag: got %0b want 1", ovf);
        end
    endtask

    task automatic test_overflow_neg();
        logic signed [15:0] exp_y;
`ifdef FIR_DECIM_SAT_EN
        exp_y = -16'sd32768;
`else
        exp_y = 16'sd0;
`endif
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, -32768, 1'b1, 1'b0, 1'b0);
        n_compared++;
        if (y_valid !== 1'b1 || y !== exp_y) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_neg_y: got valid=%0b y=%0d want 1/%0d", y_valid, y, exp_y);
        end
        n_compared++;
        if (ovf !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_neg_flag: got %0b want 1", ovf);
        end
        drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
        n_compared++;
        if (ovf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_clear: got %0b want 0", ovf);
        end
    endtask

    task automatic test_fifo_full();
        int exp_seq[4] = '{2, 4, 6, 8};
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            for (int i = 0; i < 4; i++) drive_cycle(1'b1, k, 1'b0, 1'b0, 1'b0);
        end
        n_compared++;
        if (drop !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_no_drop_yet: got %0b want 0", drop);
        end
        // Fifth frame: the dump coincides with a clr_flags pulse; set must win.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (drop !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_drop_set_wins: got %0b want 1", drop);
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (y_valid !== 1'b1 || y !== 16'(exp_seq[i])) begin
                n_mismatched++;
                $display("[TB] FAIL fifo_order[%0d]: got valid=%0b y=%0d want 1/%0d",
                         i, y_valid, y, exp_seq[i]);
            end
            drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        end
        n_compared++;
        if (y_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_drained: got valid=%0b want 0", y_valid);
        end
    endtask

    task automatic test_gaps();
        int n_out;
        n_out = 0;
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive_cycle((i % 2) == 0, 10, 1'b1, 1'b0, 1'b0);
            if (y_valid === 1'b1) n_out++;
            n_compared++;
            if (y_valid !== (i == 6)) begin
                n_mismatched++;
                $display("[TB] FAIL gaps_valid[%0d]: got %0b want %0b", i, y_valid, (i == 6));
            end
            if (i == 6) begin
                n_compared++;
                if (y !== 16'sd20) begin
                    n_mismatched++;
                    $display("[TB] FAIL gaps_y: got %0d want 20", y);
                end
            end
        end
        n_compared++;
        if (n_out != 1) begin
            n_mismatched++;
            $display("[TB] FAIL gaps_count: got %0d outputs want 1", n_out);
        end
    endtask

    task automatic test_reset_midframe();
        int n_out;
        n_out = 0;
        drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1000, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1000, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i < 4, 10, 1'b1, 1'b0, 1'b0);
            if (y_valid === 1'b1) begin
                n_out++;
                n_compared++;
                if (i != 3 || y !== 16'sd20) begin
                    n_mismatched++;
                    $display("[TB] FAIL midreset_out: cycle %0d got y=%0d want 20 at cycle 3", i, y);
                end
            end
        end
        n_compared++;
        if (n_out != 1) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_count: got %0d outputs want 1", n_out);
        end
    endtask

    task automatic test_random();
        bit xv, rdy, clr, rs;
        int xs;
        logic signed [15:0] exp_y;
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            xv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 5);
            clr = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 7))
                0:       xs = 32767;
                1:       xs = -32768;
                default: xs = int'($urandom_range(0, 65535)) - 32768;
            endcase
            drive_cycle(xv, xs, rdy, clr, rs);
            n_compared++;
            if (y_valid !== (m_fifo.size() != 0)) begin
                n_mismatched++;
                $display("[TB] FAIL rand_valid[%0d]: got %0b want %0b", c, y_valid, (m_fifo.size() != 0));
            end
            if (m_fifo.size() != 0) begin
                exp_y = 16'(m_fifo[0]);
                n_compared++;
                if (y !== exp_y) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_y[%0d]: got %0d want %0d", c, y, exp_y);
                end
            end
            n_compared++;
            if (ovf !== m_ovf || drop !== m_drop) begin
                n_mismatched++;
                $display("[TB] FAIL rand_flags[%0d]: got ovf=%0b drop=%0b want %0b/%0b",
                         c, ovf, drop, m_ovf, m_drop);
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        x            = '0;
        x_valid      = 1'b0;
        y_ready      = 1'b0;
        clr_flags    = 1'b0;
        m_ovf        = 1'b0;
        m_drop       = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow_pos();
        test_overflow_neg();
        test_fifo_full();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
FIR_DECIM_OUT -- requirements
Module: fir_decim_out

Interface
REQ-001 The block SHALL have parameter DECIM, default 4, meaning decimation factor, legal values 1, 2, 4, 8 or 16.
REQ-002 The block SHALL have parameter SHIFT, default 1, meaning arithmetic right shift applied to each dumped sum, legal range 0..log2(DECIM).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port x, input, 16 bits signed: FIR output sample.
REQ-006 The block SHALL have port x_valid, input, 1 bit: x is valid this cycle; there is no backpressure on the input.
REQ-007 The block SHALL have port y, output, 16 bits signed: decimated sample at the FIFO head.
REQ-008 The block SHALL have port y_valid, output, 1 bit: y holds a valid sample.
REQ-009 The block SHALL have port y_ready, input, 1 bit: the consumer accepts y.
REQ-010 The block SHALL have port ovf, output, 1 bit: sticky flag, set when a result exceeded the signed 16-bit range.
REQ-011 The block SHALL have port drop, output, 1 bit: sticky flag, set when a result was lost because the FIFO was full.
REQ-012 The block SHALL have port clr_flags, input, 1 bit: clears ovf and drop.

Function
REQ-013 The block SHALL use a 20-bit signed accumulator acc and a phase counter in the range 0..DECIM-1; both change only on cycles where x_valid=1.
REQ-014 On an accepted sample with phase<DECIM-1, the block SHALL set acc to acc+x (sign-extended) and increment phase.
REQ-015 On an accepted sample with phase=DECIM-1 (a dump), the block SHALL form sum=acc+x, set acc to 0 and phase to 0, and push result=sum>>>SHIFT into the FIFO. The shift is arithmetic and truncates toward minus infinity.
REQ-016 The block SHALL reduce result to 16 bits according to REQ-030/031; ovf SHALL be set on the cycle after any dump where result lies outside -32768..32767.
REQ-017 The output FIFO SHALL be 4 entries deep, first-in first-out, with y and y_valid driven from registers at the head.
REQ-018 A pushed result SHALL appear on y with y_valid=1 on the cycle after the dump when the FIFO was empty, which is one cycle of latency.
REQ-019 A pop SHALL occur when y_valid=1 and y_ready=1. y SHALL hold stable while y_valid=1 and y_ready=0.
REQ-020 A push while the FIFO is full and no pop occurs SHALL discard the new result, leave FIFO contents unchanged and set drop.
REQ-021 A push and a pop in the same cycle SHALL both succeed even when the FIFO is full; occupancy is unchanged.
REQ-022 When clr_flags=1 in the same cycle a new set condition occurs, the set SHALL win.
REQ-023 The occupancy and pointer arithmetic SHALL wrap modulo 4 without corrupting order.
REQ-024 With DECIM=1, every accepted sample SHALL be a dump.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL clear acc and phase to 0 and empty the FIFO, with y=0, y_valid=0, ovf=0 and drop=0 on the next cycle.
REQ-026 A reset asserted mid-frame SHALL discard the partial sum; the first frame after reset SHALL start at phase 0.
REQ-027 The block SHALL ignore x_valid, y_ready and clr_flags on cycles where rst=1.

Configuration
REQ-028 The macro FIR_DECIM_SAT_EN SHALL select the output reduction mode.
REQ-029 The reduction mode SHALL be fixed at compile time.
REQ-030 With FIR_DECIM_SAT_EN defined, an out-of-range result SHALL clamp to 32767 or -32768.
REQ-031 Without FIR_DECIM_SAT_EN, an out-of-range result SHALL be truncated to its low 16 bits (two's-complement wrap); ovf SHALL still be set in both modes.

Verification
REQ-032 The bench SHALL cover: DECIM=4, SHIFT=1, y_ready=1, x=100,200,300,400 -> y=500, y_valid=1 for one cycle, one cycle after the 4th sample, ovf=0.
REQ-033 The bench SHALL cover: 4 samples of 32767 -> with FIR_DECIM_SAT_EN y=32767; without it y=-2; ovf=1 in both modes.
REQ-034 The bench SHALL cover: 4 samples of -32768 -> with FIR_DECIM_SAT_EN y=-32768; without it y=0; ovf=1; then clr_flags pulse -> ovf=0.
REQ-035 The bench SHALL cover: y_ready=0, five frames of constant x=k (k=1..5) -> FIFO holds 4k/2 for k=1..4 and drop=1; y_ready=1 then yields 2,4,6,8 in order, then y_valid=0.
REQ-036 The bench SHALL cover: x_valid toggling 1,0,1,0,... with x=10 -> one output of 20 per 8 cycles; phase holds during gaps.
REQ-037 The bench SHALL cover: 2 samples of 1000, rst for 1 cycle, then 4 samples of 10 -> a single output of 20, with no contribution from the pre-reset samples.
